// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared widths and access state type for the byte-wide memory master
package cpu_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_master_if.sv
// rtl/mem_master_if.sv - core request/response handshake plus byte-wide memory port
interface mem_master_if;
  import cpu_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_word;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [BYTE_W-1:0] mem_writeData;
  logic              mem_writeEnable;
  logic [BYTE_W-1:0] mem_readData;

  modport master (
    input  req_valid, req_write, req_word, req_addr, req_wdata,
    input  resp_ready, mem_readData,
    output req_ready, resp_valid, resp_rdata,
    output mem_address, mem_writeData, mem_writeEnable
  );

  modport slave (
    output req_valid, req_write, req_word, req_addr, req_wdata,
    output resp_ready, mem_readData,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_address, mem_writeData, mem_writeEnable
  );

endinterface

// File: rtl/mem_master.sv
// rtl/mem_master.sv - splits 8/16-bit core accesses into little-endian byte cycles on an 8-bit memory
module mem_master
  import cpu_mem_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mem_master_if.master bus
);

  mem_state_t        state;
  mem_state_t        state_next;

  logic              write_q;
  logic              word_q;
  logic [BYTE_W-1:0] wdata_hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BYTE_W-1:0] wbyte_q;
  logic [WORD_W-1:0] rdata_q;

  logic              req_ready_c;
  logic              resp_valid_c;
  logic              we_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.req_valid) state_next = ACC0;
      ACC0: state_next = word_q ? ACC1 : RESP;
      ACC1: state_next = RESP;
      RESP: if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    we_c         = 1'b0;
    case (state)
      IDLE:       req_ready_c  = 1'b1;
      ACC0, ACC1: we_c         = write_q;
      RESP:       resp_valid_c = 1'b1;
      default:    req_ready_c  = 1'b0;
    endcase
  end

  // Address/data are registered one cycle ahead so they are valid for the whole byte cycle
  // and simply hold their last value once the access is over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q    <= 1'b0;
      word_q     <= 1'b0;
      wdata_hi_q <= '0;
      addr_q     <= '0;
      wbyte_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q    <= bus.req_write;
            word_q     <= bus.req_word;
            wdata_hi_q <= bus.req_wdata[WORD_W-1:BYTE_W];
            addr_q     <= bus.req_addr;
            wbyte_q    <= bus.req_wdata[BYTE_W-1:0];
            rdata_q    <= '0;
          end
        end
        ACC0: begin
          if (!write_q) rdata_q[BYTE_W-1:0] <= bus.mem_readData;
          if (word_q) begin
            addr_q  <= addr_q + ADDR_W'(1);
            wbyte_q <= wdata_hi_q;
          end
        end
        ACC1: begin
          if (!write_q) rdata_q[WORD_W-1:BYTE_W] <= bus.mem_readData;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready       = req_ready_c;
  assign bus.resp_valid      = resp_valid_c;
  assign bus.resp_rdata      = rdata_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_writeData   = wbyte_q;
  assign bus.mem_writeEnable = we_c;

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - randomized self-checking bench for mem_master against a transaction-level memory model
module tb_mem_master;
  import cpu_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_master_if bus();

  mem_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  wr_t        wq[$];

  logic        pend;
  logic [15:0] pa;
  logic [7:0]  pd;

  int vectors = 0;
  int miscompares = 0;

  assign bus.mem_readData = mem[bus.mem_address];

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic scramble();
    bus.req_valid = 1'($urandom);
    bus.req_write = 1'($urandom);
    bus.req_word  = 1'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 16'($urandom);
  endtask

  // Drives one request and reports what the bus did; expectations live in the callers.
  task automatic transact(input logic w, input logic wd, input logic [15:0] a, input logic [15:0] d,
                          input int hold, output bit ok, output int lat, output logic [15:0] rd,
                          output logic [15:0] a0, output logic [15:0] a1, output int we_err,
                          output int hold_err, output int resp_cyc, output bit post_ok);
    int n;
    ok = 1'b0; lat = 0; rd = '0; a0 = '0; a1 = '0;
    we_err = 0; hold_err = 0; resp_cyc = 0; post_ok = 1'b0;
    wq.delete();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_word   = wd;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.resp_ready = (hold == 0);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    lat = 1;
    a0  = bus.mem_address;
    a1  = a0;
    if (bus.mem_writeEnable !== w || bus.req_ready !== 1'b0) we_err++;
    scramble();
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid === 1'b1) break;
      a1 = bus.mem_address;
      if (bus.mem_writeEnable !== w || bus.req_ready !== 1'b0) we_err++;
      scramble();
    end
    bus.req_valid = 1'b0;
    if (bus.resp_valid !== 1'b1) return;
    ok       = 1'b1;
    rd       = bus.resp_rdata;
    resp_cyc = 1;
    if (bus.mem_writeEnable !== 1'b0 || bus.req_ready !== 1'b0) we_err++;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) resp_cyc++;
      if (bus.resp_rdata !== rd || bus.req_ready !== 1'b0 || bus.mem_writeEnable !== 1'b0) hold_err++;
      bus.req_valid = (hold >= 3 && k == 1);
      if (k == hold) bus.resp_ready = 1'b1;
    end
    @(negedge clk);
    post_ok = (bus.resp_valid === 1'b0 && bus.req_ready === 1'b1);
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_word  = 1'b1;
    bus.req_addr  = 16'h1234;
    bus.req_wdata = 16'h5678;
    repeat (3) @(negedge clk);
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    vectors++; if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    vectors++; if (bus.resp_rdata !== 16'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0000", bus.resp_rdata); end
    vectors++; if (bus.mem_writeEnable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", bus.mem_writeEnable); end
    vectors++; if (bus.mem_address !== 16'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0000", bus.mem_address); end
    vectors++; if (bus.mem_writeData !== 8'h0) begin miscompares++; $display("FAIL reset_wdata: got %h want 00", bus.mem_writeData); end
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_byte_load();
    bit ok, post; int lat, we_err, hold_err, rc; logic [15:0] rd, a0, a1;
    poke(16'h0005, 8'hA7);
    transact(1'b0, 1'b0, 16'h0005, 16'($urandom), 0, ok, lat, rd, a0, a1, we_err, hold_err, rc, post);
    vectors++; if (!ok) begin miscompares++; $display("FAIL byte_load_done: got %0d want 1", ok); end
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL byte_load_latency: got %0d want 2", lat); end
    vectors++; if (rd !== 16'h00A7) begin miscompares++; $display("FAIL byte_load_rdata: got %h want 00a7", rd); end
    vectors++; if (a0 !== 16'h0005) begin miscompares++; $display("FAIL byte_load_addr: got %h want 0005", a0); end
    vectors++; if (we_err != 0 || wq.size() != 0) begin miscompares++; $display("FAIL byte_load_we: got %0d bad cycles %0d writes want 0", we_err, wq.size()); end
    vectors++; if (!post) begin miscompares++; $display("FAIL byte_load_resp_len: got %0d want 1", post); end
  endtask

  task automatic test_word_store_load();
    bit ok, post; int lat, we_err, hold_err, rc; logic [15:0] rd, a0, a1;
    transact(1'b1, 1'b1, 16'h0010, 16'hBEEF, 0, ok, lat, rd, a0, a1, we_err, hold_err, rc, post);
    ref_mem[16'h0010] = 8'hEF;
    ref_mem[16'h0011] = 8'hBE;
    vectors++; if (!ok || lat != 3) begin miscompares++; $display("FAIL word_store_latency: got %0d want 3", lat); end
    vectors++; if (rd !== 16'h0) begin miscompares++; $display("FAIL word_store_rdata: got %h want 0000", rd); end
    vectors++; if (wq.size() != 2) begin miscompares++; $display("FAIL word_store_pulses: got %0d want 2", wq.size()); end
    else begin
      vectors++; if (wq[0] !== {16'h0010, 8'hEF}) begin miscompares++; $display("FAIL word_store_lo: got %h want 0010ef", wq[0]); end
      vectors++; if (wq[1] !== {16'h0011, 8'hBE}) begin miscompares++; $display("FAIL word_store_hi: got %h want 0011be", wq[1]); end
    end
    transact(1'b0, 1'b1, 16'h0010, 16'($urandom), 0, ok, lat, rd, a0, a1, we_err, hold_err, rc, post);
    vectors++; if (!ok || lat != 3) begin miscompares++; $display("FAIL word_load_latency: got %0d want 3", lat); end
    vectors++; if (rd !== 16'hBEEF) begin miscompares++; $display("FAIL word_load_rdata: got %h want beef", rd); end
  endtask

  task automatic test_wrap();
    bit ok, post; int lat, we_err, hold_err, rc; logic [15:0] rd, a0, a1;
    poke(16'hFFFF, 8'h34);
    poke(16'h0000, 8'h12);
    transact(1'b0, 1'b1, 16'hFFFF, 16'h0, 0, ok, lat, rd, a0, a1, we_err, hold_err, rc, post);
    vectors++; if (a0 !== 16'hFFFF || a1 !== 16'h0000) begin miscompares++; $display("FAIL wrap_addr_seq: got %h,%h want ffff,0000", a0, a1); end
    vectors++; if (rd !== 16'h1234) begin miscompares++; $display("FAIL wrap_rdata: got %h want 1234", rd); end
  endtask

  task automatic test_backpressure();
    bit ok, post; int lat, we_err, hold_err, rc; logic [15:0] rd, a0, a1, a, want;
    a = 16'($urandom);
    want = {ref_mem[16'(a + 16'd1)], ref_mem[a]};
    transact(1'b0, 1'b1, a, 16'($urandom), 4, ok, lat, rd, a0, a1, we_err, hold_err, rc, post);
    vectors++; if (rc != 5) begin miscompares++; $display("FAIL bp_valid_cycles: got %0d want 5", rc); end
    vectors++; if (hold_err != 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable cycles want 0", hold_err); end
    vectors++; if (rd !== want) begin miscompares++; $display("FAIL bp_rdata: got %h want %h", rd, want); end
    vectors++; if (!post) begin miscompares++; $display("FAIL bp_release: got %0d want 1", post); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [3];
    int acc_at [3];
    int na, nr;
    na = 0; nr = 0;
    for (int k = 0; k < 3; k++) begin addrs[k] = 16'($urandom); acc_at[k] = 0; end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_word   = 1'b0;
    bus.req_addr   = addrs[0];
    bus.req_valid  = 1'b1;
    for (int n = 0; n < 40 && nr < 3; n++) begin
      if (bus.resp_valid === 1'b1) begin
        vectors++;
        if (bus.resp_rdata !== {8'h00, ref_mem[addrs[nr]]}) begin
          miscompares++; $display("FAIL b2b_rdata%0d: got %h want %h", nr, bus.resp_rdata, {8'h00, ref_mem[addrs[nr]]});
        end
        nr++;
      end
      if (bus.req_ready === 1'b1 && na < 3) begin
        acc_at[na] = n;
        bus.req_addr = addrs[na];
        na++;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    vectors++; if (nr != 3) begin miscompares++; $display("FAIL b2b_responses: got %0d want 3", nr); end
    vectors++; if (acc_at[1] - acc_at[0] != 3 || acc_at[2] - acc_at[1] != 3) begin
      miscompares++; $display("FAIL b2b_spacing: got %0d,%0d want 3,3", acc_at[1] - acc_at[0], acc_at[2] - acc_at[1]);
    end
  endtask

  task automatic test_reset_mid_store();
    bit ok, post; int lat, we_err, hold_err, rc; logic [15:0] rd, a0, a1, a, d;
    logic [7:0] old_hi;
    a = 16'($urandom_range(16'h0100, 16'hFF00));
    d = 16'($urandom);
    old_hi = ref_mem[a + 16'd1];
    wq.delete();
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_word = 1'b1;
    bus.req_addr = a; bus.req_wdata = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    vectors++; if (bus.mem_writeEnable !== 1'b1 || bus.mem_address !== a + 16'd1) begin
      miscompares++; $display("FAIL rst_mid_acc1: got we %b addr %h want 1 %h", bus.mem_writeEnable, bus.mem_address, a + 16'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.mem_writeEnable !== 1'b0) begin miscompares++; $display("FAIL rst_mid_we: got %b want 0", bus.mem_writeEnable); end
    vectors++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_handshake: got ready %b valid %b want 1 0", bus.req_ready, bus.resp_valid);
    end
    vectors++; if (bus.mem_address !== 16'h0 || bus.mem_writeData !== 8'h0 || bus.resp_rdata !== 16'h0) begin
      miscompares++; $display("FAIL rst_mid_outputs: got %h %h %h want 0000 00 0000", bus.mem_address, bus.mem_writeData, bus.resp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ref_mem[a] = d[7:0];
    vectors++; if (wq.size() != 1) begin miscompares++; $display("FAIL rst_mid_writes: got %0d want 1", wq.size()); end
    transact(1'b0, 1'b1, a, 16'h0, 0, ok, lat, rd, a0, a1, we_err, hold_err, rc, post);
    vectors++; if (!ok || lat != 3 || rd !== {old_hi, d[7:0]}) begin
      miscompares++; $display("FAIL rst_mid_reload: got %h lat %0d want %h lat 3", rd, lat, {old_hi, d[7:0]});
    end
  endtask

  task automatic test_random();
    bit ok, post; int lat, we_err, hold_err, rc, hold; logic [15:0] rd, a0, a1, a, d, an, want;
    logic w, wd;
    wr_t exp_w[$];
    for (int t = 0; t < 40; t++) begin
      w    = 1'($urandom);
      wd   = 1'($urandom);
      a    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      d    = 16'($urandom);
      hold = $urandom_range(0, 2);
      an   = a + 16'd1;
      exp_w.delete();
      if (w) begin
        want = 16'h0;
        exp_w.push_back({a, d[7:0]});
        ref_mem[a] = d[7:0];
        if (wd) begin
          exp_w.push_back({an, d[15:8]});
          ref_mem[an] = d[15:8];
        end
      end else begin
        want = wd ? {ref_mem[an], ref_mem[a]} : {8'h00, ref_mem[a]};
      end
      transact(w, wd, a, d, hold, ok, lat, rd, a0, a1, we_err, hold_err, rc, post);
      vectors++; if (!ok || lat != (wd ? 3 : 2)) begin miscompares++; $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, wd ? 3 : 2); end
      vectors++; if (rd !== want) begin miscompares++; $display("FAIL rand%0d_rdata: got %h want %h", t, rd, want); end
      vectors++; if (a0 !== a || (wd && a1 !== an)) begin miscompares++; $display("FAIL rand%0d_addr: got %h,%h want %h,%h", t, a0, a1, a, an); end
      vectors++; if (we_err != 0 || hold_err != 0 || !post || rc != hold + 1) begin
        miscompares++; $display("FAIL rand%0d_protocol: got we_err %0d hold_err %0d resp %0d want 0 0 %0d", t, we_err, hold_err, rc, hold + 1);
      end
      vectors++; if (wq.size() != exp_w.size()) begin miscompares++; $display("FAIL rand%0d_write_count: got %0d want %0d", t, wq.size(), exp_w.size()); end
      else begin
        for (int i = 0; i < exp_w.size(); i++) begin
          vectors++; if (wq[i] !== exp_w[i]) begin miscompares++; $display("FAIL rand%0d_write%0d: got %h want %h", t, i, wq[i], exp_w[i]); end
        end
      end
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_word   = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    // Memory commits on the rising edge, so a write cut off by reset never lands.
    fork
      forever begin
        @(negedge clk);
        pend = bus.mem_writeEnable;
        pa   = bus.mem_address;
        pd   = bus.mem_writeData;
        @(posedge clk);
        if (pend === 1'b1 && rst_n === 1'b1) begin
          mem[pa] = pd;
          wq.push_back({pa, pd});
        end
      end
    join_none
    test_reset();
    test_byte_load();
    test_word_store_load();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_store();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
